// File: rtl/alu_issue.sv
// Single-issue operand/control stage for a 4-bit combinational ALU with an 8x4 register file; ALU_ISSUE_FWD_EN forwards same-edge writes into operands.
// Latency: accept at edge N, res_valid after edge N+1; at least 3 cycles per instruction.
// Backpressure: holds the result in DONE until res_ready; in_ready is low outside IDLE.
module alu_issue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [2:0] in_rd,
    input  logic [2:0] in_rs1,
    input  logic [2:0] in_rs2,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sl,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_rd,
    output logic       busy
);

    localparam int NREG = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NREG-1:0][3:0]   rf_q, rf_d;
    logic [3:0]             alu_a_q, alu_a_d;
    logic [3:0]             alu_b_q, alu_b_d;
    logic [2:0]             alu_sl_q, alu_sl_d;
    logic                   res_valid_q, res_valid_d;
    logic [7:0]             res_data_q, res_data_d;
    logic [2:0]             res_rd_q, res_rd_d;
    logic                   ready_en_q, ready_en_d;

    logic       ext_wr;
    logic [3:0] rs1_val;
    logic [3:0] rs2_val;

    assign ext_wr    = wr_en && (wr_addr != 3'd0);
    assign in_ready  = ready_en_q && (state_q == IDLE);
    assign busy      = (state_q == EXEC) || (state_q == DONE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sl    = alu_sl_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;

    // Operand read; r0 is hardwired to zero regardless of array contents.
    always_comb begin
        rs1_val = (in_rs1 == 3'd0) ? 4'd0 : rf_q[in_rs1];
        rs2_val = (in_rs2 == 3'd0) ? 4'd0 : rf_q[in_rs2];
`ifdef ALU_ISSUE_FWD_EN
        if (ext_wr && (wr_addr == in_rs1)) rs1_val = wr_data;
        if (ext_wr && (wr_addr == in_rs2)) rs2_val = wr_data;
`endif
    end

    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sl_d    = alu_sl_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        ready_en_d  = 1'b1;

        if (ext_wr) rf_d[wr_addr] = wr_data;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    alu_a_d  = rs1_val;
                    alu_b_d  = rs2_val;
                    alu_sl_d = in_op;
                    res_rd_d = in_rd;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = alu_out;
                res_valid_d = 1'b1;
                // Applied after the external write so writeback wins a collision.
                if (res_rd_q != 3'd0) rf_d[res_rd_q] = alu_out[3:0];
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rf_q        <= '0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_sl_q    <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
            res_rd_q    <= 3'd0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sl_q    <= alu_sl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            ready_en_q  <= ready_en_d;
        end
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Single-issue operand/control stage feeding the 4-bit combinational ALU (`alu_v`: inputs a, b, SL; 8-bit output out). It holds an 8-entry × 4-bit register file and accepts one instruction per valid/ready handshake. It drives the ALU from registered operands and captures the 8-bit result. It writes the low nibble back to the register file and presents the full result downstream on a valid/ready interface.

## Interface
- `NREG`, 8, register-file entries; fixed at 8 (3-bit addresses); r0 reads as zero.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: instruction valid.
- `in_ready` out 1: stage can accept an instruction.
- `in_op` in 3: ALU select, passed to `alu_sl`.
- `in_rd` in 3: destination register.
- `in_rs1` in 3: source register for ALU input a.
- `in_rs2` in 3: source register for ALU input b.
- `wr_en` in 1: external register-file write strobe.
- `wr_addr` in 3: external write address.
- `wr_data` in 4: external write data.
- `alu_a` out 4: to ALU a; registered.
- `alu_b` out 4: to ALU b; registered.
- `alu_sl` out 3: to ALU SL; registered.
- `alu_out` in 8: from ALU out; combinational return.
- `res_valid` out 1: result valid.
- `res_ready` in 1: downstream accepts result.
- `res_data` out 8: captured ALU result.
- `res_rd` out 3: destination tag of `res_data`.
- `busy` out 1: high in EXEC or DONE.

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- **IDLE:** `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `alu_a`=R[rs1], `alu_b`=R[rs2], `alu_sl`=`in_op`, and `res_rd`=`in_rd`, then go to EXEC.
  - Reading r0 always yields 0.
- **EXEC:** one cycle. The ALU settles combinationally from the registered operands. At the closing edge:
  - `res_data` ← `alu_out`.
  - R[rd] ← `alu_out[3:0]` unless rd=0.
  - `res_valid` ← 1.
  - Go to DONE.
- **DONE:** `res_valid`=1. `res_data` and `res_rd` are held stable until `res_ready`=1. On the handshake edge, `res_valid` ← 0 and the FSM goes to IDLE.
- **External write:** `wr_en` writes R[`wr_addr`] on any cycle and in any state. Writes to address 0 are ignored.
- **Write collision:** if the EXEC writeback and `wr_en` target the same nonzero address on the same edge, the writeback wins.
- **Operand/write race:** if `wr_en` targets rs1/rs2 on the same edge as instruction acceptance, the operand value is set by the macro (see Configuration).
- `alu_a`, `alu_b` and `alu_sl` hold their values after EXEC until the next acceptance.

## Timing
- **Reset values (immediately on `rst_n` low):**
  - State IDLE.
  - All R[i]=0.
  - `alu_a`=0, `alu_b`=0, `alu_sl`=0.
  - `res_valid`=0, `res_data`=0, `res_rd`=0, `busy`=0.
  - `in_ready`=0 while `rst_n`=0; `in_ready`=1 from the first cycle after release.
- **Latency and throughput:**
  - Instruction accepted at edge N → `res_valid` high after edge N+1.
  - Writeback visible to a read accepted at edge N+2 or later.
  - Minimum 3 cycles per instruction when `res_ready` is tied high.
- **Reset mid-operation:** asserting `rst_n` in EXEC or DONE aborts the instruction. There is no writeback, and `res_valid` drops asynchronously.
- **Ordering:** no pipelining and no overlap; `in_ready`=0 throughout EXEC and DONE.
- **Width rules:** `res_data` is the full 8-bit `alu_out`. Writeback truncates to bits [3:0].

## Configuration
- `ALU_ISSUE_FWD_EN` defined:
  - An external write (`wr_en`, nonzero `wr_addr`) coinciding with instruction acceptance forwards `wr_data` into `alu_a` and/or `alu_b` when `wr_addr` matches rs1/rs2.
  - Both operands are forwarded if both match.
- `ALU_ISSUE_FWD_EN` undefined:
  - Operands capture the pre-edge register-file contents (old value).
  - The write still lands in R[`wr_addr`].

## Test plan
The bench ALU model returns `alu_out` = zero-extended a+b for SL=000 and {a,b} for SL=001.
- **Basic add:** write R1=0xB, R2=0x3; issue op=000, rs1=1, rs2=2, rd=3, `res_ready`=1 → `res_valid` one cycle after acceptance, `res_data`=0x0E, `res_rd`=3, R3=0xE.
- **Backpressure:** op=001, rs1=1, rs2=2, rd=4, `res_ready`=0 for 5 cycles → `res_data`=0xB3 held stable, `in_ready`=0 throughout; then `res_ready`=1 → IDLE next cycle, R4=0x3.
- **r0 handling:** issue rs1=0, rs2=2, rd=0, op=000 → `res_data`=0x03, R0 still reads 0; `wr_en` to address 0 has no effect.
- **Same-edge race:** R5=0x1; `wr_en`, addr 5, data 0x7 on the acceptance edge of rs1=5, rs2=0 → `alu_a`=0x7 with `ALU_ISSUE_FWD_EN`, 0x1 without; R5=0x7 in both builds.
- **Collision:** writeback to rd=6 and `wr_en` to addr 6 on the same edge → R6 holds the ALU low nibble.
- **Reset:** assert `rst_n` low during DONE → `res_valid`=0 immediately, all registers 0, `in_ready`=1 one cycle after release.
